// File: rtl/gray_updown_counter_if.sv
// rtl/gray_updown_counter_if.sv - control/status bundle for the Gray up/down counter
interface gray_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             En;
  logic             Dir;
  logic             Load;
  logic [WIDTH-1:0] LoadVal;
  logic             ClrFlags;
  logic [WIDTH-1:0] Output;
  logic [WIDTH-1:0] BinOut;
  logic             Overflow;
  logic             Underflow;
  logic             WrapPulse;

  modport master (
    output En, Dir, Load, LoadVal, ClrFlags,
    input  Output, BinOut, Overflow, Underflow, WrapPulse
  );

  modport slave (
    input  En, Dir, Load, LoadVal, ClrFlags,
    output Output, BinOut, Overflow, Underflow, WrapPulse
  );
endinterface

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - WIDTH-bit up/down Gray counter with load, sticky wrap flags, optional saturation
// Binary count is the state; Gray is encoded from the next binary value so both outputs come straight from flops.
module gray_updown_counter #(
  parameter int WIDTH    = 3,
  parameter int SATURATE = 0,
  parameter int INIT     = 0
) (
  input logic                  Clk,
  input logic                  Reset,
  gray_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    // Clearing first lets an event on the same edge re-set its own flag.
    bin_d  = bin_q;
    ovf_d  = ovf_q & ~bus.ClrFlags;
    unf_d  = unf_q & ~bus.ClrFlags;
    wrap_d = 1'b0;
    if (bus.Load) begin
      bin_d = bus.LoadVal;
    end else if (bus.En) begin
      if (bus.Dir) begin
        if (bin_q == MAX_VAL) begin
          ovf_d  = 1'b1;
          wrap_d = 1'b1;
          bin_d  = (SATURATE != 0) ? MAX_VAL : '0;
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == '0) begin
          unf_d  = 1'b1;
          wrap_d = 1'b1;
          bin_d  = (SATURATE != 0) ? '0 : MAX_VAL;
        end else begin
          bin_d = bin_q - WIDTH'(1);
        end
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q  <= INIT_VAL;
      gray_q <= INIT_VAL ^ (INIT_VAL >> 1);
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.BinOut    = bin_q;
  assign bus.Output    = gray_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
  assign bus.WrapPulse = wrap_q;
endmodule
